eeprom_i2c_master: RTL and testbench



---
 rtl/eeprom_i2c_master_if.sv | 22 ++
 rtl/eeprom_i2c_master.sv | 227 ++++++++++++++++++++++
 tb/tb_eeprom_i2c_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_i2c_master_if.sv
// Host-side request/response bundle for the serial EEPROM master.
// The host drives requests through 'master'; the bus engine uses 'slave'.
interface eeprom_i2c_master_if;
   logic        wr_req;
   logic        rd_req;
   logic [10:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        done;
   logic        ack_err;
   logic        busy;

   modport master (
      output wr_req, rd_req, addr, wdata,
      input  rdata, done, ack_err, busy
   );

   modport slave (
      input  wr_req, rd_req, addr, wdata,
      output rdata, done, ack_err, busy
   );
endinterface

// File: rtl/eeprom_i2c_master.sv
// Two-wire master turning single-byte host requests into EEPROM byte-write
// and random-read bus sequences; SCL period is four CLK_DIV-long quarters.
module eeprom_i2c_master #(
   parameter int unsigned CLK_DIV   = 25,
   parameter bit          CHECK_ACK = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   eeprom_i2c_master_if.slave   host,
   output logic                 scl,
   inout  wire                  sda
);
   localparam int unsigned QCNT_W = $clog2(CLK_DIV);
   localparam logic [QCNT_W-1:0] QMAX = QCNT_W'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_TX_BYTE, S_TX_ACK, S_RESTART,
      S_RX_BYTE, S_M_NACK, S_STOP, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [QCNT_W-1:0] qcnt_q, qcnt_d;
   logic [1:0]        phase_q, phase_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic              op_rd_q, op_rd_d;
   logic [10:0]       addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rx_q, rx_d;
   logic              nack_q, nack_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              ack_err_q, ack_err_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              scl_q, scl_d;
   logic              sda_oe_q, sda_oe_d;
   logic              sda_out_q, sda_out_d;

   logic              sda_in;
   logic              qend, samp, pend;
   logic [7:0]        tx_cur;

   assign sda_in = sda;
   assign sda    = sda_oe_q ? sda_out_q : 1'bz;
   assign scl    = scl_q;

   assign host.rdata   = rdata_q;
   assign host.done    = done_q;
   assign host.ack_err = ack_err_q;
   assign host.busy    = busy_q;

   // Byte shifted out for a given byte slot: ctrl-write, address, then data or ctrl-read.
   function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic rd,
                                          input logic [10:0] a, input logic [7:0] d);
      logic [7:0] b;
      case (idx)
         2'd0:    b = {4'b1010, a[10:8], 1'b0};
         2'd1:    b = a[7:0];
         default: b = rd ? {4'b1010, a[10:8], 1'b1} : d;
      endcase
      return b;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         qcnt_q     <= '0;
         phase_q    <= '0;
         bitcnt_q   <= '0;
         byte_idx_q <= '0;
         op_rd_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rx_q       <= '0;
         nack_q     <= 1'b0;
         rdata_q    <= '0;
         ack_err_q  <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         scl_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
         sda_out_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         phase_q    <= phase_d;
         bitcnt_q   <= bitcnt_d;
         byte_idx_q <= byte_idx_d;
         op_rd_q    <= op_rd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rx_q       <= rx_d;
         nack_q     <= nack_d;
         rdata_q    <= rdata_d;
         ack_err_q  <= ack_err_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         scl_q      <= scl_d;
         sda_oe_q   <= sda_oe_d;
         sda_out_q  <= sda_out_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      qcnt_d     = qcnt_q;
      phase_d    = phase_q;
      bitcnt_d   = bitcnt_q;
      byte_idx_d = byte_idx_q;
      op_rd_d    = op_rd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rx_d       = rx_q;
      nack_d     = nack_q;
      rdata_d    = rdata_q;
      ack_err_d  = ack_err_q;
      scl_d      = 1'b1;
      sda_oe_d   = 1'b0;
      sda_out_d  = 1'b1;
      tx_cur     = '0;

      qend = (qcnt_q == QMAX);
      samp = qend && (phase_q == 2'd2);
      pend = qend && (phase_q == 2'd3);

      if (state_q == S_IDLE) begin
         if (host.wr_req || host.rd_req) begin
            op_rd_d    = !host.wr_req;
            addr_d     = host.addr;
            wdata_d    = host.wdata;
            ack_err_d  = 1'b0;
            qcnt_d     = '0;
            phase_d    = '0;
            bitcnt_d   = '0;
            byte_idx_d = '0;
            state_d    = S_START;
         end
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end else begin
         qcnt_d = qend ? '0 : qcnt_q + QCNT_W'(1);
         if (qend) phase_d = phase_q + 2'd1;

         // Slave data is taken at the end of the first SCL-high quarter.
         if (samp && state_q == S_TX_ACK) nack_d = sda_in;
         if (samp && state_q == S_RX_BYTE) rx_d = {rx_q[6:0], sda_in};

         if (pend) begin
            case (state_q)
               S_START: begin
                  bitcnt_d   = '0;
                  byte_idx_d = '0;
                  state_d    = S_TX_BYTE;
               end
               S_TX_BYTE: begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = S_TX_ACK;
               end
               S_TX_ACK: begin
                  if (CHECK_ACK && nack_q) begin
                     ack_err_d = 1'b1;
                     state_d   = S_STOP;
                  end else begin
                     byte_idx_d = byte_idx_q + 2'd1;
                     case (byte_idx_q)
                        2'd0:    state_d = S_TX_BYTE;
                        2'd1:    state_d = op_rd_q ? S_RESTART : S_TX_BYTE;
                        default: state_d = op_rd_q ? S_RX_BYTE : S_STOP;
                     endcase
                  end
               end
               S_RESTART: state_d = S_TX_BYTE;
               S_RX_BYTE: begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = S_M_NACK;
               end
               S_M_NACK: state_d = S_STOP;
               S_STOP: begin
                  if (op_rd_q && !ack_err_q) rdata_d = rx_q;
                  state_d = S_DONE;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end

      // Pin levels for the coming cycle are derived from the next state/phase.
      tx_cur = tx_byte(byte_idx_d, op_rd_d, addr_d, wdata_d);
      case (state_d)
         S_START: begin
            scl_d     = (phase_d != 2'd3);
            sda_oe_d  = 1'b1;
            sda_out_d = (phase_d < 2'd2);
         end
         S_TX_BYTE: begin
            scl_d     = phase_d[1];
            sda_oe_d  = 1'b1;
            sda_out_d = tx_cur[~bitcnt_d];
         end
         S_TX_ACK, S_RX_BYTE: begin
            scl_d = phase_d[1];
         end
         S_RESTART: begin
            scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
            sda_oe_d  = 1'b1;
            sda_out_d = (phase_d < 2'd2);
         end
         S_M_NACK: begin
            scl_d     = phase_d[1];
            sda_oe_d  = 1'b1;
            sda_out_d = 1'b1;
         end
         S_STOP: begin
            scl_d     = (phase_d != 2'd0);
            sda_oe_d  = 1'b1;
            sda_out_d = phase_d[1];
         end
         default: begin
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
         end
      endcase

      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end
endmodule

// File: tb/tb_eeprom_i2c_master.sv
// Bench for eeprom_i2c_master: a behavioural EEPROM slave/bus monitor plus a
// transaction-level model of expected bus traffic, latency and read data.
`timescale 1ns/1ps
module tb_eeprom_i2c_master;
   localparam int unsigned CLK_DIV = 2;
   localparam int          T       = 4 * CLK_DIV;
   localparam int          EV_ST   = 1000;
   localparam int          EV_SP   = 1001;
   localparam int          LIMIT   = 60 * T;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   eeprom_i2c_master_if host ();
   eeprom_i2c_master_if host1 ();
   wire scl, scl1;
   wire sda, sda1;
   pullup (sda);
   pullup (sda1);

   eeprom_i2c_master #(.CLK_DIV(CLK_DIV), .CHECK_ACK(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .host(host), .scl(scl), .sda(sda));
   eeprom_i2c_master #(.CLK_DIV(CLK_DIV), .CHECK_ACK(1'b1)) dut_ack (
      .clk(clk), .rst_n(rst_n), .host(host1), .scl(scl1), .sda(sda1));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
   endtask

   // Behavioural EEPROM: decodes start/stop/bits, stores writes, serves random reads.
   logic [7:0]  smem [2048];
   logic        ld_en = 1'b0;
   logic [10:0] ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        scl_p = 1'b1, sda_p = 1'b1;
   int          r = 0;
   logic [7:0]  shreg = '0;
   logic [1:0]  bidx = '0;
   logic        rd_mode = 1'b0;
   logic [2:0]  page = '0;
   logic [10:0] ptr = '0;
   logic [7:0]  rd_byte = '0;
   logic        slv_low = 1'b0;
   int          log_q[$];

   assign sda = slv_low ? 1'b0 : 1'bz;

   always @(negedge clk) begin
      scl_p <= scl;
      sda_p <= sda;
      if (ld_en) smem[ld_addr] <= ld_data;
      if (scl_p && scl && sda_p && !sda) begin
         log_q.push_back(EV_ST);
         r <= 0; bidx <= '0; rd_mode <= 1'b0; slv_low <= 1'b0;
      end else if (scl_p && scl && !sda_p && sda) begin
         log_q.push_back(EV_SP);
         r <= 0; rd_mode <= 1'b0; slv_low <= 1'b0;
      end else if (!scl_p && scl) begin
         if (r < 8) begin
            shreg <= {shreg[6:0], sda};
            r     <= r + 1;
         end else begin
            log_q.push_back(int'({shreg, sda}));
            r    <= 0;
            bidx <= bidx + 2'd1;
            if (rd_mode) rd_mode <= 1'b0;
            else if (bidx == 2'd0) begin
               if (shreg[0]) begin
                  rd_mode <= 1'b1;
                  rd_byte <= smem[ptr];
               end else page <= shreg[3:1];
            end else if (bidx == 2'd1) ptr <= {page, shreg};
            else if (bidx == 2'd2) smem[ptr] <= shreg;
         end
      end else if (scl_p && !scl) begin
         slv_low <= rd_mode && (r < 8) && !rd_byte[3'(7 - r)];
      end
   end

   // Stop-condition counter on the ACK-checking instance's bus.
   logic scl1_p = 1'b1, sda1_p = 1'b1;
   int   stop1_cnt = 0;
   always @(negedge clk) begin
      scl1_p <= scl1;
      sda1_p <= sda1;
      if (scl1_p && scl1 && !sda1_p && sda1) stop1_cnt <= stop1_cnt + 1;
   end

   logic [7:0] ref_mem [2048];
   int         exp_q[$];

   // Expected bus events for one request, from the byte-write / random-read rules.
   task automatic build_expect(input bit is_rd, input logic [10:0] a, input logic [7:0] d);
      logic [7:0] ctrl_w, ctrl_r;
      ctrl_w = {4'b1010, a[10:8], 1'b0};
      ctrl_r = {4'b1010, a[10:8], 1'b1};
      exp_q.delete();
      exp_q.push_back(EV_ST);
      exp_q.push_back(int'({ctrl_w, 1'b1}));
      exp_q.push_back(int'({a[7:0], 1'b1}));
      if (is_rd) begin
         exp_q.push_back(EV_ST);
         exp_q.push_back(int'({ctrl_r, 1'b1}));
         exp_q.push_back(int'({ref_mem[a], 1'b1}));
      end else begin
         exp_q.push_back(int'({d, 1'b1}));
      end
      exp_q.push_back(EV_SP);
   endtask

   task automatic do_txn(input bit wr, input bit rd, input logic [10:0] a, input logic [7:0] d);
      int cyc;
      bit is_rd, busy_bad;
      is_rd = !wr && rd;
      build_expect(is_rd, a, d);
      if (!is_rd) ref_mem[a] = d;
      log_q.delete();
      @(negedge clk);
      host.wr_req = wr; host.rd_req = rd; host.addr = a; host.wdata = d;
      @(negedge clk);
      host.wr_req = 1'b0; host.rd_req = 1'b0;
      cyc = 1; busy_bad = 1'b0;
      while (!host.done && cyc < LIMIT) begin
         if (!host.busy) busy_bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      check_eq("latency", cyc, is_rd ? 39 * T + 1 : 29 * T + 1);
      check_eq("busy_during", busy_bad, 1'b0);
      check_eq("busy_at_done", host.busy, 1'b0);
      check_eq("ack_err", host.ack_err, 1'b0);
      if (is_rd) check_eq("rdata", host.rdata, ref_mem[a]);
      @(negedge clk);
      check_eq("done_pulse", host.done, 1'b0);
      check_eq("bus_len", log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         check_eq("bus_event", log_q[i], exp_q[i]);
      if (!is_rd) check_eq("slave_mem", smem[a], d);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_nack_txn(input logic [10:0] a, input logic [7:0] d);
      int cyc, stops0;
      stops0 = stop1_cnt;
      @(negedge clk);
      host1.wr_req = 1'b1; host1.addr = a; host1.wdata = d;
      @(negedge clk);
      host1.wr_req = 1'b0;
      check_eq("ack_err_cleared", host1.ack_err, 1'b0);
      cyc = 1;
      while (!host1.done && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("nack_latency", cyc, 11 * T + 1);
      check_eq("nack_ack_err", host1.ack_err, 1'b1);
      check_eq("nack_busy", host1.busy, 1'b0);
      check_eq("nack_rdata", host1.rdata, 8'h00);
      check_eq("nack_stop", stop1_cnt - stops0, 1);
      repeat (3) @(negedge clk);
      check_eq("ack_err_sticky", host1.ack_err, 1'b1);
   endtask

   initial begin
      int op;
      logic [10:0] a;
      logic [7:0]  d;
      rst_n = 1'b0;
      host.wr_req = 1'b0; host.rd_req = 1'b0; host.addr = '0; host.wdata = '0;
      host1.wr_req = 1'b0; host1.rd_req = 1'b0; host1.addr = '0; host1.wdata = '0;

      for (int i = 0; i < 2048; i++) begin
         @(posedge clk);
         ld_en = 1'b1; ld_addr = 11'(i); ld_data = 8'($urandom);
         ref_mem[i] = ld_data;
      end
      @(posedge clk);
      ld_en = 1'b0;

      @(negedge clk);
      check_eq("rst_scl", scl, 1'b1);
      check_eq("rst_sda", sda, 1'b1);
      check_eq("rst_busy", host.busy, 1'b0);
      check_eq("rst_done", host.done, 1'b0);
      check_eq("rst_ack_err", host.ack_err, 1'b0);
      check_eq("rst_rdata", host.rdata, 8'h00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      do_txn(1'b1, 1'b0, 11'h123, 8'h5A);
      do_txn(1'b1, 1'b0, 11'h7FF, 8'h3C);
      do_txn(1'b0, 1'b1, 11'h7FF, 8'h00);
      @(posedge clk);
      ld_en = 1'b1; ld_addr = 11'h000; ld_data = 8'hC3; ref_mem[0] = 8'hC3;
      @(posedge clk);
      ld_en = 1'b0;
      do_txn(1'b0, 1'b1, 11'h000, 8'h00);
      do_txn(1'b1, 1'b1, 11'h055, 8'h11);
      do_txn(1'b0, 1'b1, 11'h055, 8'h00);

      do_nack_txn(11'h2A0, 8'h99);
      do_nack_txn(11'h013, 8'h42);

      // Reset in the middle of the address byte of a write.
      log_q.delete();
      @(negedge clk);
      host.wr_req = 1'b1; host.addr = 11'h3A5; host.wdata = 8'hE1;
      @(negedge clk);
      host.wr_req = 1'b0;
      repeat (14 * T) @(negedge clk);
      check_eq("mid_busy", host.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("arst_scl", scl, 1'b1);
      check_eq("arst_sda", sda, 1'b1);
      check_eq("arst_busy", host.busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("arst_mem", smem[11'h3A5], ref_mem[11'h3A5]);
      do_txn(1'b1, 1'b0, 11'h010, 8'h77);
      do_txn(1'b0, 1'b1, 11'h010, 8'h00);

      for (int k = 0; k < 12; k++) begin
         op = int'($urandom_range(0, 2));
         a  = 11'($urandom);
         d  = 8'($urandom);
         do_txn(op != 1, op != 0, a, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
